rf_wb_scheduler: RTL and testbench

RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

---
 rtl/rf_wb_scheduler.sv | 136 +++++++++++++
 tb/tb_rf_wb_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
//   Arbitrates two writeback requesters (0 = ALU, 1 = LSU) onto a single
//   register-file write port. It also keeps a per-register busy scoreboard
//   that stalls the issue stage on RAW/WAW hazards.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   wb0_valid/ready/addr/data   requester 0 writeback handshake
//   wb1_valid/ready/addr/data   requester 1 writeback handshake
//   iss_valid/rd/rs1/rs2        instruction presented by the issue stage
//   iss_stall                   issue must hold (a referenced register is busy)
//   rf_we/rf_wa/rf_wd           registered write-port drive, one cycle after accept
//   busy_vec                    scoreboard, bit n = register n has a pending producer
//   idle                        scoreboard empty and no write in flight
module rf_wb_scheduler #(
    parameter int NUM_REGS  = 8,
    parameter int REG_WIDTH = 256,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb0_valid,
    output logic                 wb0_ready,
    input  logic [ADDR_W-1:0]    wb0_addr,
    input  logic [REG_WIDTH-1:0] wb0_data,
    input  logic                 wb1_valid,
    output logic                 wb1_ready,
    input  logic [ADDR_W-1:0]    wb1_addr,
    input  logic [REG_WIDTH-1:0] wb1_data,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_rd,
    input  logic [ADDR_W-1:0]    iss_rs1,
    input  logic [ADDR_W-1:0]    iss_rs2,
    output logic                 iss_stall,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_wa,
    output logic [REG_WIDTH-1:0] rf_wd,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic                 idle
);

    // Round-robin pointer: 1 means requester 1 won the most recent transfer.
    // Its reset value of 1 hands the first contested cycle to requester 0.
    logic                 r_last_gnt1;
    logic [NUM_REGS-1:0]  r_busy;
    logic                 r_rf_we;
    logic [ADDR_W-1:0]    r_rf_wa;
    logic [REG_WIDTH-1:0] r_rf_wd;

    logic                 w_xfer;
    logic                 w_wb_in_range;
    logic [ADDR_W-1:0]    w_wb_addr;
    logic [REG_WIDTH-1:0] w_wb_data;
    logic [NUM_REGS-1:0]  w_set;
    logic [NUM_REGS-1:0]  w_clr;
    logic [NUM_REGS-1:0]  w_busy_nxt;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < $unsigned(NUM_REGS);
    endfunction

    // Out-of-range addresses never match a scoreboard bit, so they read as not busy.
    function automatic logic f_busy_at(input logic [NUM_REGS-1:0] vec,
                                       input logic [ADDR_W-1:0]   a);
        logic b;
        b = 1'b0;
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            if (32'(a) == n) b = vec[n];
        end
        return b;
    endfunction

    // Grants are masked by rst so no transfer can complete during reset.
    always_comb begin
        wb0_ready = 1'b0;
        wb1_ready = 1'b0;
        if (!rst) begin
            if (wb0_valid && wb1_valid) begin
                wb0_ready = r_last_gnt1;
                wb1_ready = !r_last_gnt1;
            end else begin
                wb0_ready = wb0_valid;
                wb1_ready = wb1_valid;
            end
        end
    end

    assign w_xfer        = wb0_ready | wb1_ready;
    assign w_wb_addr     = wb1_ready ? wb1_addr : wb0_addr;
    assign w_wb_data     = wb1_ready ? wb1_data : wb0_data;
    assign w_wb_in_range = f_in_range(w_wb_addr);

    assign iss_stall = iss_valid & (f_busy_at(r_busy, iss_rs1) |
                                    f_busy_at(r_busy, iss_rs2) |
                                    f_busy_at(r_busy, iss_rd));

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            if (w_xfer && 32'(w_wb_addr) == n)
                w_clr[n] = 1'b1;
            if (iss_valid && !iss_stall && 32'(iss_rd) == n)
                w_set[n] = 1'b1;
        end
    end

    // Set is applied after clear so a new producer wins over a retiring one.
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt1 <= 1'b1;
            r_busy      <= '0;
            r_rf_we     <= 1'b0;
            r_rf_wa     <= '0;
            r_rf_wd     <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_rf_we <= w_xfer && w_wb_in_range;
            if (w_xfer)
                r_last_gnt1 <= wb1_ready;
            if (w_xfer && w_wb_in_range) begin
                r_rf_wa <= w_wb_addr;
                r_rf_wd <= w_wb_data;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_wa    = r_rf_wa;
    assign rf_wd    = r_rf_wd;
    assign busy_vec = r_busy;
    assign idle     = (r_busy == '0) && !r_rf_we;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;

    localparam int NR = 8;
    localparam int RW = 256;
    localparam int AW = 5;

    localparam logic [RW-1:0] D0 = '0;
    localparam logic [RW-1:0] DA = {8{32'hAAAABEEF}};
    localparam logic [RW-1:0] DC = {8{32'hCAFEBABE}};
    localparam logic [RW-1:0] D5 = {8{32'h55550005}};
    localparam logic [RW-1:0] D6 = {8{32'h66660006}};
    localparam logic [RW-1:0] D7 = {8{32'h77770007}};
    localparam logic [RW-1:0] D2 = {8{32'h22220002}};

    logic          clk = 1'b0;
    logic          rst;
    logic          wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [AW-1:0] wb0_addr, wb1_addr;
    logic [RW-1:0] wb0_data, wb1_data;
    logic          iss_valid, iss_stall;
    logic [AW-1:0] iss_rd, iss_rs1, iss_rs2;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [RW-1:0] rf_wd;
    logic [NR-1:0] busy_vec;
    logic          idle;

    rf_wb_scheduler #(.NUM_REGS(NR), .REG_WIDTH(RW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_stall(iss_stall),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .busy_vec(busy_vec), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          w0v; logic [AW-1:0] w0a; logic [RW-1:0] w0d;
        logic          w1v; logic [AW-1:0] w1a; logic [RW-1:0] w1d;
        logic          iv;  logic [AW-1:0] rd, rs1, rs2;
        logic          e_r0, e_r1, e_st, e_we;
        logic [AW-1:0] e_wa; logic [RW-1:0] e_wd;
        logic [NR-1:0] e_busy; logic e_idle;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        wb0_valid = v.w0v; wb0_addr = v.w0a; wb0_data = v.w0d;
        wb1_valid = v.w1v; wb1_addr = v.w1a; wb1_data = v.w1d;
        iss_valid = v.iv;  iss_rd = v.rd; iss_rs1 = v.rs1; iss_rs2 = v.rs2;
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
        iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        n_vec++;
        chk({tag, ".wb0_ready"}, RW'(wb0_ready), RW'(v.e_r0));
        chk({tag, ".wb1_ready"}, RW'(wb1_ready), RW'(v.e_r1));
        chk({tag, ".iss_stall"}, RW'(iss_stall), RW'(v.e_st));
        chk({tag, ".rf_we"},     RW'(rf_we),     RW'(v.e_we));
        chk({tag, ".rf_wa"},     RW'(rf_wa),     RW'(v.e_wa));
        chk({tag, ".rf_wd"},     rf_wd,          v.e_wd);
        chk({tag, ".busy_vec"},  RW'(busy_vec),  RW'(v.e_busy));
        chk({tag, ".idle"},      RW'(idle),      RW'(v.e_idle));
    endtask

    // One synchronous reset cycle, leaving inputs idle just after the edge.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // rst w0v w0a   w0d w1v w1a   w1d iv  rd     rs1    rs2   | r0 r1 st we wa    wd  busy    idle
        tbl.push_back('{1'b1, 1'b1, 5'd3, DA, 1'b1, 5'd4, DC, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, D0, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b1, 5'd3, 5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, D0, 8'h00, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 5'd3, DA, 1'b0, 5'd0, D0, 1'b1, 5'd4, 5'd3,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd0, D0, 8'h08, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b1, 5'd4, 5'd3,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd3, DA, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b1, 5'd9, DC, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd3, DA, 8'h10, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b1, 5'd9, 5'd20, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd3, DA, 8'h10, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 5'd7, D7, 1'b0, 5'd0, D0, 1'b1, 5'd4, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd3, DA, 8'h10, 1'b0});
        // issue rd=7 alongside a writeback to 7: the new producer's busy bit must survive
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b1, 5'd7, DC, 1'b1, 5'd7, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd7, D7, 8'h10, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b1, 5'd0, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7, DC, 8'h90, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 5'd4, D5, 1'b1, 5'd7, D7, 1'b1, 5'd1, 5'd4,  5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 5'd7, DC, 8'h90, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b1, 5'd7, D7, 1'b1, 5'd1, 5'd4,  5'd2,  1'b0, 1'b1, 1'b0, 1'b1, 5'd4, D5, 8'h80, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd7, D7, 8'h02, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 5'd1, D5, 1'b0, 5'd0, D0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd7, D7, 8'h02, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd1, D5, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd1, D5, 8'h00, 1'b1});

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check_all($sformatf("tbl%0d", i), tbl[i]);
            @(posedge clk); #1;
        end

        // Contested round-robin: both requesters valid for three cycles.
        do_reset();
        v = '{1'b0, 1'b1, 5'd5, D5, 1'b1, 5'd7, D7, 1'b0, 5'd0, 5'd0, 5'd0,
              1'b1, 1'b0, 1'b0, 1'b0, 5'd0, D0, 8'h00, 1'b1};
        drive(v); @(negedge clk); check_all("rr1", v); @(posedge clk); #1;
        v = '{1'b0, 1'b1, 5'd6, D6, 1'b1, 5'd7, D7, 1'b0, 5'd0, 5'd0, 5'd0,
              1'b0, 1'b1, 1'b0, 1'b1, 5'd5, D5, 8'h00, 1'b0};
        drive(v); @(negedge clk); check_all("rr2", v); @(posedge clk); #1;
        v = '{1'b0, 1'b1, 5'd6, D6, 1'b1, 5'd2, D2, 1'b0, 5'd0, 5'd0, 5'd0,
              1'b1, 1'b0, 1'b0, 1'b1, 5'd7, D7, 8'h00, 1'b0};
        drive(v); @(negedge clk); check_all("rr3", v); @(posedge clk); #1;
        v = '{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b0, 5'd0, 5'd0, 5'd0,
              1'b0, 1'b0, 1'b0, 1'b1, 5'd6, D6, 8'h00, 1'b0};
        drive(v); @(negedge clk); check_all("rr4", v); @(posedge clk); #1;

        // Fill the scoreboard, then reset in the same cycle as a writeback.
        do_reset();
        for (int r = 0; r < NR; r++) begin
            idle_inputs();
            iss_valid = 1'b1;
            iss_rd = AW'(r); iss_rs1 = AW'(r); iss_rs2 = AW'(r);
            @(negedge clk);
            n_vec++;
            chk($sformatf("fill%0d.iss_stall", r), RW'(iss_stall), RW'(1'b0));
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        n_vec++;
        chk("full.busy_vec", RW'(busy_vec), RW'(8'hFF));
        chk("full.idle",     RW'(idle),     RW'(1'b0));
        @(posedge clk); #1;

        v = '{1'b1, 1'b1, 5'd3, DA, 1'b0, 5'd0, D0, 1'b0, 5'd0, 5'd0, 5'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 5'd0, D0, 8'hFF, 1'b0};
        drive(v); @(negedge clk); check_all("rstwb", v); @(posedge clk); #1;
        v = '{1'b0, 1'b0, 5'd0, D0, 1'b0, 5'd0, D0, 1'b0, 5'd5, 5'd6, 5'd7,
              1'b0, 1'b0, 1'b0, 1'b0, 5'd0, D0, 8'h00, 1'b1};
        drive(v); @(negedge clk); check_all("postrst", v); @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
